// File: rtl/sha_msg_feeder.sv
// Gathers a message from a valid/ready source into blocks of up to BLOCK_WORDS
// words, streams each block to the hash core and captures the final digest.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for msg_start
// INIT      | pulse sha_init, clear buffer, count and last flag
// FILL      | accept source words into the block buffer
// START     | request a block once the core is free
// SEND      | stream buffered words to the core
// WAIT_HASH | wait for the core digest of the final block
module sha_msg_feeder #(
    parameter int BLOCK_WORDS = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_start,
    input  logic [31:0]  s_word,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic         sha_init,
    output logic         mode_block,
    output logic         start_block,
    output logic [31:0]  block_word,
    output logic         block_word_valid,
    output logic         block_last,
    output logic [5:0]   words_in_block,
    input  logic         core_busy,
    input  logic         core_buffer_full,
    input  logic [511:0] core_out,
    input  logic         core_out_ready,
    output logic [511:0] digest,
    output logic         digest_valid,
    output logic         active
);

    localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [5:0] FULL_COUNT = 6'(BLOCK_WORDS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        FILL      = 3'd2,
        START     = 3'd3,
        SEND      = 3'd4,
        WAIT_HASH = 3'd5
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [31:0]    buffer [BLOCK_WORDS];
    logic [5:0]     count;
    logic [IW-1:0]  rd_ptr;
    logic           last_flag;
    logic [511:0]   digest_q;
    logic           digest_valid_q;

    logic           handshake;
    logic           consume;
    logic           final_word;

    assign active           = (state != IDLE);
    assign mode_block       = active;
    assign block_last       = last_flag;
    assign words_in_block   = count;
    assign digest           = digest_q;
    assign digest_valid     = digest_valid_q;

    assign handshake  = s_valid && s_ready;
    // The core only takes a word once it has gone busy after start_block.
    assign consume    = block_word_valid && core_busy && !core_buffer_full;
    assign final_word = (6'(rd_ptr) == (count - 6'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (msg_start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                state_next = FILL;
            end
            FILL: begin
                if ((count == FULL_COUNT) || last_flag) begin
                    state_next = START;
                end
            end
            START: begin
                if (!core_busy && !core_buffer_full) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (consume && final_word) begin
                    state_next = last_flag ? WAIT_HASH : FILL;
                end
            end
            WAIT_HASH: begin
                if (core_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready          = 1'b0;
        sha_init         = 1'b0;
        start_block      = 1'b0;
        block_word       = '0;
        block_word_valid = 1'b0;
        case (state)
            INIT: begin
                sha_init = 1'b1;
            end
            FILL: begin
                s_ready = (count < FULL_COUNT) && !last_flag;
            end
            START: begin
                start_block = !core_busy && !core_buffer_full;
            end
            SEND: begin
                block_word       = buffer[rd_ptr];
                block_word_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                buffer[i] <= '0;
            end
        end else if (handshake) begin
            buffer[count[IW-1:0]] <= s_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count          <= '0;
            rd_ptr         <= '0;
            last_flag      <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            digest_valid_q <= 1'b0;
            case (state)
                INIT: begin
                    count     <= '0;
                    rd_ptr    <= '0;
                    last_flag <= 1'b0;
                end
                FILL: begin
                    if (handshake) begin
                        count <= count + 6'd1;
                        if (s_last) begin
                            last_flag <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (consume) begin
                        if (final_word) begin
                            // Count and flag stay visible through WAIT_HASH on the final block.
                            if (!last_flag) begin
                                count  <= '0;
                                rd_ptr <= '0;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + IW'(1);
                        end
                    end
                end
                WAIT_HASH: begin
                    if (core_out_ready) begin
                        digest_q       <= core_out;
                        digest_valid_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Randomized bench for sha_msg_feeder: messages are split into expected blocks
// arithmetically and compared with what a simple hash-core model observes.
module tb_sha_msg_feeder;

    localparam int BW = 18;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_start;
    logic [31:0]  s_word;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic         sha_init;
    logic         mode_block;
    logic         start_block;
    logic [31:0]  block_word;
    logic         block_word_valid;
    logic         block_last;
    logic [5:0]   words_in_block;
    logic         core_busy;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready;
    logic [511:0] digest;
    logic         digest_valid;
    logic         active;

    sha_msg_feeder #(.BLOCK_WORDS(BW)) dut (
        .clk              (clk),
        .reset            (reset),
        .msg_start        (msg_start),
        .s_word           (s_word),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .sha_init         (sha_init),
        .mode_block       (mode_block),
        .start_block      (start_block),
        .block_word       (block_word),
        .block_word_valid (block_word_valid),
        .block_last       (block_last),
        .words_in_block   (words_in_block),
        .core_busy        (core_busy),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .active           (active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int           blk_sizes[$];
    bit           blk_lasts[$];
    logic [31:0]  consumed[$];
    int           init_cnt = 0;
    int           digest_cnt = 0;
    int           pulse_err = 0;
    int           mode_err = 0;
    int           hold_err = 0;

    int           cm_phase = 0;
    int           cm_cnt = 0;
    int           cm_need = 0;
    int           cm_got = 0;
    bit           cm_last = 1'b0;
    logic         nb_busy = 1'b0;
    logic         nb_ready = 1'b0;
    logic [511:0] nb_out = '0;
    logic [511:0] exp_digest = '0;
    bit           force_full = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("reset_outputs",
            64'({s_ready, sha_init, mode_block, start_block, block_word, block_word_valid,
                 block_last, words_in_block, digest_valid, active}), 64'd0);
        checks++;
        assert (digest === 512'd0) else begin
            errors++;
            $error("FAIL reset_digest observed=%h expected=0", digest);
        end
    endtask

    // Hash-core model and protocol monitor: drives core inputs on the falling
    // edge, samples DUT outputs 2 time units later.
    initial begin : core_monitor
        bit          cons;
        bit          p_start;
        bit          p_init;
        bit          p_dv;
        bit          p_pend;
        logic [31:0] p_word;
        int          cur_size;
        bit          cur_last;
        p_start = 0; p_init = 0; p_dv = 0; p_pend = 0; p_word = '0;
        cur_size = 0; cur_last = 0;
        forever begin
            @(negedge clk);
            core_busy        = nb_busy;
            core_buffer_full = force_full || (nb_busy && cm_phase == 2 && $urandom_range(0, 3) == 0);
            core_out_ready   = nb_ready;
            core_out         = nb_out;
            #2;
            if (reset) begin
                p_start = 0; p_init = 0; p_dv = 0; p_pend = 0;
                cm_phase = 0; nb_busy = 1'b0; nb_ready = 1'b0;
            end else begin
                cons = block_word_valid && core_busy && !core_buffer_full;
                if (start_block) begin
                    blk_sizes.push_back(int'(words_in_block));
                    blk_lasts.push_back(block_last);
                    cur_size = int'(words_in_block);
                    cur_last = block_last;
                end
                if (sha_init) init_cnt++;
                if (digest_valid) digest_cnt++;
                if ((p_start && start_block) || (p_init && sha_init) || (p_dv && digest_valid))
                    pulse_err++;
                if ((mode_block !== active) || (s_ready && block_word_valid))
                    mode_err++;
                if (p_pend && block_word_valid && (block_word !== p_word))
                    hold_err++;
                if (block_word_valid && ((int'(words_in_block) != cur_size) || (block_last != cur_last)))
                    hold_err++;
                if (cons) consumed.push_back(block_word);
                p_pend  = block_word_valid && !cons;
                p_word  = block_word;
                p_start = start_block;
                p_init  = sha_init;
                p_dv    = digest_valid;

                case (cm_phase)
                    0: begin
                        nb_ready = 1'b0;
                        if (start_block) begin
                            cm_need  = int'(words_in_block);
                            cm_got   = 0;
                            cm_last  = block_last;
                            cm_cnt   = int'($urandom_range(1, 3));
                            cm_phase = 1;
                        end
                    end
                    1: begin
                        cm_cnt--;
                        if (cm_cnt == 0) begin
                            nb_busy  = 1'b1;
                            cm_phase = 2;
                        end
                    end
                    2: begin
                        if (cons) cm_got++;
                        if (cm_got >= cm_need) begin
                            cm_cnt   = int'($urandom_range(1, 4));
                            cm_phase = 3;
                        end
                    end
                    3: begin
                        cm_cnt--;
                        if (cm_cnt == 0) begin
                            nb_busy = 1'b0;
                            if (cm_last) begin
                                for (int k = 0; k < 16; k++) nb_out[k*32 +: 32] = $urandom;
                                exp_digest = nb_out;
                                nb_ready   = 1'b1;
                                cm_phase   = 4;
                            end else begin
                                cm_phase = 0;
                            end
                        end
                    end
                    default: begin
                        nb_ready = 1'b0;
                        cm_phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic run_msg(input int n, input bit use_seq, input int poke_fill,
                           input bit poke_wait, input int full_at, input int abort_at,
                           output bit aborted);
        logic [31:0] w[$];
        int          base_blk, base_cons, base_init, base_dig, nb, i, cyc, exp_size;
        bit          poked, full_done;
        logic [31:0] w0;
        int          c0;
        aborted = 1'b0;
        for (int k = 0; k < n; k++) w.push_back(use_seq ? 32'(k + 1) : $urandom);
        nb        = (n + BW - 1) / BW;
        base_blk  = blk_sizes.size();
        base_cons = consumed.size();
        base_init = init_cnt;
        base_dig  = digest_cnt;

        @(negedge clk); msg_start = 1'b1;
        @(negedge clk); msg_start = 1'b0;

        i = 0; cyc = 0; poked = 0; full_done = 0;
        while (i < n && cyc < 3000 && !aborted) begin
            @(negedge clk);
            cyc++;
            msg_start = (poke_fill > 0) && (i == poke_fill) && !poked;
            if (msg_start) poked = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                s_valid = 1'b1; s_word = w[i]; s_last = (i == n - 1);
            end else begin
                s_valid = 1'b0; s_word = $urandom; s_last = 1'($urandom_range(0, 1));
            end
            #3;
            if (s_valid && s_ready) i++;
            if (abort_at > 0 && consumed.size() - base_cons >= abort_at) aborted = 1'b1;
            if (full_at > 0 && !full_done && consumed.size() - base_cons >= full_at) begin
                full_done  = 1'b1;
                force_full = 1'b1;
                @(negedge clk); s_valid = 1'b0; msg_start = 1'b0;
                #3;
                c0 = consumed.size();
                w0 = block_word;
                repeat (10) @(negedge clk);
                #3;
                chk("full_hold_count", 64'(consumed.size()), 64'(c0));
                chk("full_hold_word", 64'(block_word), 64'(w0));
                chk("full_hold_valid", 64'(block_word_valid), 64'd1);
                force_full = 1'b0;
            end
        end
        if (aborted) return;

        @(negedge clk); s_valid = 1'b0; s_last = 1'b0; msg_start = 1'b0;
        chk("feed_words", 64'(i), 64'(n));

        cyc = 0; poked = 0;
        while (digest_cnt == base_dig && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            msg_start = 1'b0;
            if (poke_wait && !poked && cm_phase == 3 && cm_last) begin
                msg_start = 1'b1;
                poked     = 1'b1;
            end
            #3;
        end
        @(negedge clk); msg_start = 1'b0;
        repeat (4) @(negedge clk);
        #3;

        chk("sha_init_count", 64'(init_cnt - base_init), 64'd1);
        chk("block_count", 64'(blk_sizes.size() - base_blk), 64'(nb));
        for (int b = 0; b < nb && base_blk + b < blk_sizes.size(); b++) begin
            exp_size = (b == nb - 1) ? n - b * BW : BW;
            chk("block_words", 64'(blk_sizes[base_blk + b]), 64'(exp_size));
            chk("block_last", 64'(blk_lasts[base_blk + b]), 64'(b == nb - 1));
        end
        chk("word_count", 64'(consumed.size() - base_cons), 64'(n));
        for (int k = 0; k < n && base_cons + k < consumed.size(); k++)
            chk("word_order", 64'(consumed[base_cons + k]), 64'(w[k]));
        chk("digest_pulses", 64'(digest_cnt - base_dig), 64'd1);
        checks++;
        assert (digest === exp_digest) else begin
            errors++;
            $error("FAIL digest observed=%h expected=%h", digest, exp_digest);
        end
        chk("idle_after", 64'(active), 64'd0);
        chk("protocol_errs", 64'(pulse_err + mode_err + hold_err), 64'd0);
    endtask

    initial begin : stimulus
        bit ab;
        reset = 1'b1; msg_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_word = '0;
        repeat (3) @(negedge clk);
        #3;
        chk_reset_outputs();
        @(negedge clk); reset = 1'b0;

        run_msg(5, 1'b1, 0, 1'b0, 0, 0, ab);
        run_msg(40, 1'b0, 0, 1'b0, 0, 0, ab);
        run_msg(18, 1'b0, 0, 1'b0, 0, 0, ab);
        run_msg(10, 1'b0, 4, 1'b1, 0, 0, ab);
        run_msg(30, 1'b0, 0, 1'b0, 5, 0, ab);
        run_msg(36, 1'b0, 0, 1'b0, 0, 0, ab);

        run_msg(30, 1'b0, 0, 1'b0, 0, 3, ab);
        chk("reached_send_word3", 64'(ab), 64'd1);
        @(negedge clk); reset = 1'b1; s_valid = 1'b0; msg_start = 1'b0;
        @(negedge clk); reset = 1'b0;
        #3;
        chk_reset_outputs();

        run_msg(7, 1'b0, 0, 1'b0, 0, 0, ab);
        for (int r = 0; r < 4; r++) run_msg(int'($urandom_range(1, 50)), 1'b0, 0, 1'b0, 0, 0, ab);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
